wb_sdram_resp_model: RTL and testbench

- Synthesizable Wishbone classic responder that emulates the SDRAM controller's host-side behaviour.
- Used as a stand-in DUT to qualify the Wishbone driver and monitor tasks, and as a golden responder in the bench.
- Provides word-addressed memory with byte-select writes, configurable read/write wait states, an init-done delay after reset, and periodic refresh windows that stall new accesses.

---
 rtl/wb_sdram_resp_model_if.sv | 24 ++
 rtl/wb_sdram_resp_model.sv | 158 +++++++++++++++
 tb/tb_wb_sdram_resp_model.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sdram_resp_model_if.sv
// Wishbone classic bus bundle between a host master and the SDRAM responder model.
interface wb_sdram_resp_model_if #(
    parameter int dw = 32
);
    logic            wb_cyc_i;
    logic            wb_stb_i;
    logic            wb_we_i;
    logic [25:0]     wb_addr_i;
    logic [dw-1:0]   wb_dat_i;
    logic [dw/8-1:0] wb_sel_i;
    logic [2:0]      wb_cti_i;
    logic [dw-1:0]   wb_dat_o;
    logic            wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_sdram_resp_model.sv
// Wishbone classic responder mimicking the host side of an SDRAM controller:
// word memory with byte lanes, fixed read/write wait states, a power-up init
// delay and periodic refresh windows that hold off new accesses.
module wb_sdram_resp_model #(
    parameter int dw          = 32,
    parameter int AW          = 12,
    parameter int RD_WAIT     = 3,
    parameter int WR_WAIT     = 1,
    parameter int INIT_CYCLES = 100,
    parameter int RF_PERIOD   = 780,
    parameter int RF_CYCLES   = 8
) (
    input  logic                 sys_clk,
    input  logic                 RESET,
    wb_sdram_resp_model_if.slave wb,
    output logic                 sdr_init_done,
    output logic                 rf_busy_o
);
    localparam int NB  = dw / 8;
    localparam int IW  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int PW  = (RF_PERIOD > 1) ? $clog2(RF_PERIOD) : 1;
    localparam int CW  = (RF_CYCLES > 1) ? $clog2(RF_CYCLES) : 1;

    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [PW-1:0] RF_LAST   = PW'(RF_PERIOD - 1);
    localparam logic [CW-1:0] RFC_LAST  = CW'(RF_CYCLES - 1);
    localparam logic [3:0]    WR_LOAD   = 4'(WR_WAIT);
    localparam logic [3:0]    RD_LOAD   = 4'(RD_WAIT);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_REFRESH
    } state_t;

    state_t          state;
    logic [IW-1:0]   init_cnt;
    logic [PW-1:0]   rf_cnt;
    logic [CW-1:0]   rf_len;
    logic [3:0]      wait_cnt;
    logic            rf_pending;

    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic [dw-1:0]   dat_q;
    logic [NB-1:0]   sel_q;

    logic [dw-1:0]   mem [2**AW];

    logic            accept;
    logic            bus_req;
    logic            unused_bits;

    // Cycle type tag and the upper address bits play no part in decoding.
    assign unused_bits = ^{wb.wb_cti_i, wb.wb_addr_i[25:AW]};

    assign bus_req = wb.wb_cyc_i & wb.wb_stb_i;
    // A pending refresh always beats a new request in IDLE.
    assign accept  = (state == S_IDLE) && !rf_pending && bus_req;

    // Control FSM, refresh timer and registered bus outputs.
    always_ff @(posedge sys_clk) begin
        if (RESET) begin
            state         <= S_INIT;
            init_cnt      <= '0;
            rf_cnt        <= '0;
            rf_len        <= '0;
            wait_cnt      <= '0;
            rf_pending    <= 1'b0;
            sdr_init_done <= 1'b0;
            rf_busy_o     <= 1'b0;
            wb.wb_ack_o   <= 1'b0;
            wb.wb_dat_o   <= '0;
        end else begin
            unique case (state)
                S_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        sdr_init_done <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (rf_pending) begin
                        rf_pending <= 1'b0;
                        rf_busy_o  <= 1'b1;
                        rf_len     <= '0;
                        state      <= S_REFRESH;
                    end else if (accept) begin
                        wait_cnt <= wb.wb_we_i ? WR_LOAD : RD_LOAD;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus_req) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        wb.wb_ack_o <= 1'b1;
                        if (!we_q) begin
                            wb.wb_dat_o <= mem[addr_q];
                        end
                        state <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    wb.wb_ack_o <= 1'b0;
                    state       <= S_IDLE;
                end
                S_REFRESH: begin
                    if (rf_len == RFC_LAST) begin
                        rf_busy_o <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        rf_len <= rf_len + 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase

            // Free-running refresh timer; placed after the FSM so a fresh
            // expiry on the same edge as a service is not lost.
            if (sdr_init_done) begin
                if (rf_cnt == RF_LAST) begin
                    rf_cnt     <= '0;
                    rf_pending <= 1'b1;
                end else begin
                    rf_cnt <= rf_cnt + 1'b1;
                end
            end
        end
    end

    // Capture the request fields at acceptance; data path needs no reset.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            addr_q <= wb.wb_addr_i[AW-1:0];
            we_q   <= wb.wb_we_i;
            dat_q  <= wb.wb_dat_i;
            sel_q  <= wb.wb_sel_i;
        end
    end

    // Commit write lanes on the edge leaving ACK; contents survive RESET.
    always_ff @(posedge sys_clk) begin
        if (!RESET && (state == S_ACK) && we_q) begin
            for (int i = 0; i < NB; i++) begin
                if (sel_q[i]) begin
                    mem[addr_q][8*i +: 8] <= dat_q[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_sdram_resp_model.sv
`timescale 1ns/1ps
module tb_wb_sdram_resp_model;
    localparam int DW          = 32;
    localparam int AW          = 12;
    localparam int RD_WAIT     = 3;
    localparam int WR_WAIT     = 1;
    localparam int INIT_CYCLES = 100;
    localparam int RF_PERIOD   = 780;
    localparam int RF_CYCLES   = 8;
    localparam int DEPTH       = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done;
    logic busy;

    wb_sdram_resp_model_if #(.dw(DW)) bus ();

    wb_sdram_resp_model #(
        .dw(DW), .AW(AW), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT),
        .INIT_CYCLES(INIT_CYCLES), .RF_PERIOD(RF_PERIOD), .RF_CYCLES(RF_CYCLES)
    ) dut (
        .sys_clk       (clk),
        .RESET         (rst),
        .wb            (bus),
        .sdr_init_done (done),
        .rf_busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: value seen at a negedge is the number of the last rising edge.
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int checks   = 0;
    int failures = 0;
    int ack_total = 0;
    int busy_cnt  = 0;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          ack_edge;
        string       name;
    } exp_t;
    exp_t sb[$];

    // Reference model state.
    logic [31:0] ref_mem [int];
    int next_rf;
    int idle_from;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    // Expected acceptance edge for a request first visible at edge s.
    function automatic int model_accept(input int s);
        int t = idle_from;
        while (1) begin
            if (next_rf < t) begin
                next_rf += RF_PERIOD;
                t += RF_CYCLES + 1;
            end else if (t >= s) begin
                return t;
            end else begin
                t++;
            end
        end
        return t;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = sel[i] ? 8'hFF : 8'h00;
        return (old & ~m) | (nw & m);
    endfunction

    // Monitor: every ack is matched against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (bus.wb_ack_o) begin
            ack_total++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: ack=1 with nothing outstanding (cycle %0d)", cyc_n);
            end else begin
                e = sb.pop_front();
                check_eq({e.name, "_ack_cycle"}, cyc_n, e.ack_edge);
                if (e.rd) check_eq({e.name, "_rdata"}, bus.wb_dat_o, e.data);
                check_eq({e.name, "_no_ack_in_refresh"}, {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic bus_idle();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    // Issue one access (called just after a negedge) and wait for its ack.
    task automatic xfer(input bit we, input logic [25:0] addr, input logic [31:0] dat,
                        input logic [3:0] sel, input string name);
        exp_t e;
        int   s, e0, key;
        bit   got;
        key = int'(addr[AW-1:0]);
        s   = cyc_n + 1;
        e0  = model_accept(s);
        e.rd       = !we;
        e.name     = name;
        e.ack_edge = e0 + (we ? WR_WAIT : RD_WAIT) + 1;
        e.data     = '0;
        if (we) begin
            ref_mem[key] = merge(ref_mem.exists(key) ? ref_mem[key] : 32'h0, dat, sel);
        end else begin
            e.data = ref_mem[key];
        end
        idle_from = e.ack_edge + 2;
        sb.push_back(e);
        bus.wb_addr_i = addr;
        bus.wb_dat_i  = dat;
        bus.wb_sel_i  = sel;
        bus.wb_we_i   = we;
        bus.wb_cti_i  = 3'($urandom_range(0, 7));
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = bus.wb_ack_o;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no ack within 100 cycles, required ack at cycle %0d", name, e.ack_edge);
            if (sb.size() > 0) void'(sb.pop_back());
        end
        bus_idle();
    endtask

    // Apply reset, check reset state, then time the init-done rise.
    task automatic reset_and_init(input bit strobe_in_init);
        int r, acks0;
        bit seen;
        rst = 1'b1;
        bus_idle();
        repeat (3) @(negedge clk);
        check_eq("reset_ack",  {31'd0, bus.wb_ack_o}, 32'd0);
        check_eq("reset_dat",  bus.wb_dat_o, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        r = cyc_n;
        rst = 1'b0;
        acks0 = ack_total;
        if (strobe_in_init) begin
            bus.wb_addr_i = 26'h010;
            bus.wb_we_i   = 1'b0;
            bus.wb_sel_i  = 4'hF;
            bus.wb_cyc_i  = 1'b1;
            bus.wb_stb_i  = 1'b1;
        end
        seen = 1'b0;
        for (int k = 0; k < INIT_CYCLES + 50 && !seen; k++) begin
            @(negedge clk);
            if (cyc_n - r == INIT_CYCLES / 2) bus_idle();
            seen = done;
        end
        check_eq("init_done_delay", seen ? (cyc_n - r) : -1, INIT_CYCLES);
        if (strobe_in_init) check_eq("init_no_ack", ack_total - acks0, 0);
        next_rf   = cyc_n + RF_PERIOD;
        idle_from = cyc_n + 1;
    endtask

    logic [25:0] pool [16];
    bit          written [16];

    initial begin
        int b0, a0, idx;
        logic [31:0] old;
        bus_idle();
        bus.wb_addr_i = '0;
        bus.wb_dat_i  = '0;
        bus.wb_sel_i  = '0;
        bus.wb_cti_i  = '0;

        reset_and_init(1'b1);

        xfer(1'b1, 26'h010, 32'hDEADBEEF, 4'hF, "wr_010");
        xfer(1'b0, 26'h010, 32'h0,        4'hF, "rd_010");
        xfer(1'b1, 26'h020, 32'hFFFFFFFF, 4'hF, "wr_020_full");
        xfer(1'b1, 26'h020, 32'h00000012, 4'b0001, "wr_020_lane0");
        xfer(1'b0, 26'h020, 32'h0,        4'hF, "rd_020");
        check_eq("model_020_merge", ref_mem[32'h020], 32'hFFFFFF12);
        xfer(1'b1, 26'h1005, 32'hA5A5A5A5, 4'hF, "wr_alias");
        xfer(1'b0, 26'h0005, 32'h0,        4'hF, "rd_alias");

        // Present a read on the cycle the refresh timer expires.
        while (cyc_n < next_rf) @(negedge clk);
        b0 = busy_cnt;
        xfer(1'b0, 26'h010, 32'h0, 4'hF, "rd_during_refresh");
        check_eq("refresh_len", busy_cnt - b0, RF_CYCLES);

        // Randomized traffic across several refresh periods.
        for (int i = 0; i < 16; i++) begin
            pool[i]    = 26'($urandom_range(0, DEPTH - 1));
            written[i] = 1'b0;
        end
        for (int n = 0; n < 250; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            idx = $urandom_range(0, 15);
            if (!written[idx] || $urandom_range(0, 1) == 0) begin
                xfer(1'b1, pool[idx] | (26'($urandom_range(0, 255)) << AW), $urandom,
                     4'($urandom_range(0, 15)) | (written[idx] ? 4'h0 : 4'hF), "rand_wr");
                written[idx] = 1'b1;
            end else begin
                xfer(1'b0, pool[idx] | (26'($urandom_range(0, 255)) << AW), 32'h0, 4'hF, "rand_rd");
            end
        end

        // Reset during a write's wait phase: no ack, no memory change.
        reset_and_init(1'b0);
        old = ref_mem[32'h010];
        a0  = ack_total;
        bus.wb_addr_i = 26'h010;
        bus.wb_dat_i  = ~old;
        bus.wb_sel_i  = 4'hF;
        bus.wb_we_i   = 1'b1;
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        @(negedge clk);
        reset_and_init(1'b0);
        check_eq("abort_no_ack", ack_total - a0, 0);
        xfer(1'b0, 26'h010, 32'h0, 4'hF, "rd_after_abort");
        check_eq("model_abort_old", ref_mem[32'h010], old);

        repeat (5) @(negedge clk);
        check_eq("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
